// File: rtl/mem_loader.sv
// mem_loader: streams bytes into memory, optionally reads them back, then releases the CPU.
// Define MEM_LOADER_VERIFY_EN to compile in the XOR checksum readback (VERIFY state).
module mem_loader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int REG_WIDTH   = 8,
  parameter int RELEASE_GAP = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [REG_WIDTH-1:0]  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_din,
  output logic                  mem_we,
  input  logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  manual_mem,
  output logic                  cpu_reset_n,
  output logic                  trigger_program,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [3:0]            GAP = 4'(RELEASE_GAP);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RELEASE, RUN} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [3:0]            gap_cnt;
  logic                  start_ok;
  logic                  accept;
  logic                  last_byte;
  logic                  gap_hit;

  assign start_ok  = start && ((state == IDLE) || (state == RUN));
  // Writes are gated by reset_n so the cycle carrying reset never commits a byte.
  assign accept    = reset_n && (state == LOAD) && din_valid;
  assign last_byte = accept && (cnt == ONE);
  assign gap_hit   = (state == RELEASE) && (gap_cnt == GAP);

`ifdef MEM_LOADER_VERIFY_EN
  function automatic logic [7:0] fold8(input logic [REG_WIDTH-1:0] d);
    logic [7:0] f;
    f = '0;
    for (int i = 0; i < REG_WIDTH; i++) begin
      f[i % 8] = f[i % 8] ^ d[i];
    end
    return f;
  endfunction

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] rcv_cnt;
  logic [7:0]            chk;
  logic [7:0]            rd_sum;
  logic [7:0]            rd_final;
  logic                  rd_vld_p1;
  logic                  issue;
  logic                  rd_last;
  logic                  rd_match;
  logic                  error_q;

  assign issue    = (state == VERIFY) && (cnt != '0);
  assign rd_last  = (state == VERIFY) && rd_vld_p1 && (rcv_cnt == ONE);
  assign rd_final = rd_sum ^ fold8(mem_dout);
  assign rd_match = (rd_final == chk);
  assign error    = error_q;
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    manual_mem      = 1'b1;
    cpu_reset_n     = 1'b0;
    din_ready       = 1'b0;
    busy            = 1'b0;
    trigger_program = 1'b0;
    done            = 1'b0;
    mem_we          = accept;
    mem_din         = accept ? din : '0;
    mem_addr        = addr;
    case (state)
      IDLE: begin
        if (start_ok) state_nx = (len == '0) ? RELEASE : LOAD;
      end
      LOAD: begin
        din_ready = reset_n;
        busy      = 1'b1;
`ifdef MEM_LOADER_VERIFY_EN
        if (last_byte) state_nx = VERIFY;
`else
        if (last_byte) state_nx = RELEASE;
`endif
      end
      VERIFY: begin
        busy = 1'b1;
`ifdef MEM_LOADER_VERIFY_EN
        if (rd_last) state_nx = rd_match ? RELEASE : IDLE;
`else
        state_nx = IDLE;
`endif
      end
      RELEASE: begin
        manual_mem      = 1'b0;
        cpu_reset_n     = 1'b1;
        busy            = 1'b1;
        trigger_program = gap_hit;
        done            = gap_hit;
        if (gap_hit) state_nx = RUN;
      end
      RUN: begin
        manual_mem  = 1'b0;
        cpu_reset_n = 1'b1;
        if (start_ok) state_nx = (len == '0) ? RELEASE : LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address/count registers shared by the write stream and the readback issue.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr    <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
    end else if (start_ok) begin
      addr    <= base_addr;
      cnt     <= len;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        addr <= addr + ONE;
        cnt  <= cnt - ONE;
      end
`ifdef MEM_LOADER_VERIFY_EN
      if (last_byte) begin
        addr <= base_q;
        cnt  <= len_q;
      end
      if (issue) begin
        addr <= addr + ONE;
        cnt  <= cnt - ONE;
      end
`endif
      if (state == RELEASE) gap_cnt <= gap_cnt + 4'd1;
    end
  end

`ifdef MEM_LOADER_VERIFY_EN
  // Readback stage p1: data for the address issued last cycle arrives on mem_dout.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q    <= '0;
      len_q     <= '0;
      rcv_cnt   <= '0;
      chk       <= '0;
      rd_sum    <= '0;
      rd_vld_p1 <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      rd_vld_p1 <= issue;
      if (start_ok) begin
        base_q  <= base_addr;
        len_q   <= len;
        chk     <= '0;
        error_q <= 1'b0;
      end
      if (accept) chk <= chk ^ fold8(din);
      if (last_byte) begin
        rcv_cnt <= len_q;
        rd_sum  <= '0;
      end
      if (rd_vld_p1 && (state == VERIFY)) begin
        rd_sum  <= rd_final;
        rcv_cnt <= rcv_cnt - ONE;
      end
      if (rd_last && !rd_match) error_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural 64K x 8 memory and a write log.
module tb_mem_loader;

  localparam int GAP = 3;
`ifdef MEM_LOADER_VERIFY_EN
  localparam int VER_CYC = 4;
`else
  localparam int VER_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] len = '0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout = '0;
  logic        manual_mem, cpu_reset_n, trigger_program, busy, done, error;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int trig_cnt = 0;
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = '0;
  logic [7:0]  mem_model [0:65535];
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  int          log_cyc[$];

  mem_loader #(.ADDR_WIDTH(16), .REG_WIDTH(8), .RELEASE_GAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .len(len),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout), .manual_mem(manual_mem),
    .cpu_reset_n(cpu_reset_n), .trigger_program(trigger_program), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_din);
      log_cyc.push_back(cyc);
      if (manual_mem === 1'b1) mem_model[mem_addr] <= mem_din;
    end
    if (trigger_program === 1'b1) trig_cnt = trig_cnt + 1;
    mem_dout <= (corrupt_en && mem_addr == corrupt_addr) ? 8'hFF : mem_model[mem_addr];
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      total++;
      if (manual_mem === 1'b1 && cpu_reset_n === 1'b1) begin
        bad++;
        $display("FAIL cpu_reset_while_manual: cpu_reset_n=%b manual_mem=%b required not both 1", cpu_reset_n, manual_mem);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    start = 1'b1;
    base_addr = b;
    len = l;
    step();
    start = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++;
    if ({manual_mem, cpu_reset_n, mem_we, din_ready, trigger_program, done, busy, error} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 10000000",
               {manual_mem, cpu_reset_n, mem_we, din_ready, trigger_program, done, busy, error});
    end
    total++;
    if ({mem_addr, mem_din} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data: addr=%h din=%h required 0000/00", mem_addr, mem_din);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [3];
    int n;
    exp_d = '{8'hA9, 8'h05, 8'h00};
    clear_log();
    do_start(16'h0600, 16'd3);
    din_valid = 1'b1;
    din = 8'hA9;
    #1;
    total++;
    if ({din_ready, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 16'h0600, 8'hA9}) begin
      bad++;
      $display("FAIL basic_first_write: rdy=%b we=%b addr=%h d=%h required 1 1 0600 a9", din_ready, mem_we, mem_addr, mem_din);
    end
    total++;
    if ({busy, manual_mem, cpu_reset_n} !== 3'b110) begin
      bad++;
      $display("FAIL basic_load_ctrl: got %b required 110", {busy, manual_mem, cpu_reset_n});
    end
    step(); din = 8'h05;
    step(); din = 8'h00;
    step(); din_valid = 1'b0;
    #1;
    total++;
    if (din_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_ready_drop: din_ready=%b required 0", din_ready);
    end
    n = 0;
    while (cpu_reset_n !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n !== VER_CYC) begin
      bad++;
      $display("FAIL basic_release_entry: cycles=%0d required %0d", n, VER_CYC);
    end
    total++;
    if ({manual_mem, busy} !== 2'b01) begin
      bad++;
      $display("FAIL basic_release_ctrl: manual_mem=%b busy=%b required 0 1", manual_mem, busy);
    end
    for (int k = 0; k < GAP; k++) begin
      total++;
      if (trigger_program !== 1'b0) begin
        bad++;
        $display("FAIL basic_early_trigger: cycle %0d trigger=%b required 0", k, trigger_program);
      end
      step();
    end
    total++;
    if ({trigger_program, done} !== 2'b11) begin
      bad++;
      $display("FAIL basic_trigger: trigger=%b done=%b required 1 1", trigger_program, done);
    end
    step();
    total++;
    if ({trigger_program, done, busy, cpu_reset_n, manual_mem} !== 5'b00010) begin
      bad++;
      $display("FAIL basic_run: got %b required 00010", {trigger_program, done, busy, cpu_reset_n, manual_mem});
    end
    total++;
    if (log_addr.size() !== 3) begin
      bad++;
      $display("FAIL basic_write_count: got %0d required 3", log_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (log_addr[i] !== 16'(16'h0600 + i) || log_data[i] !== exp_d[i]) begin
          bad++;
          $display("FAIL basic_write_%0d: addr=%h data=%h required %h %h", i, log_addr[i], log_data[i], 16'(16'h0600 + i), exp_d[i]);
        end
      end
      total++;
      if (log_cyc[2] - log_cyc[0] !== 2) begin
        bad++;
        $display("FAIL basic_back_to_back: span=%0d required 2", log_cyc[2] - log_cyc[0]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] pat [5];
    int n;
    pat = '{8'h11, 8'hEE, 8'h22, 8'hEE, 8'h33};
    clear_log();
    do_start(16'h0700, 16'd3);
    #1;
    total++;
    if ({cpu_reset_n, manual_mem} !== 2'b01) begin
      bad++;
      $display("FAIL gaps_run_restart: cpu_reset_n=%b manual_mem=%b required 0 1", cpu_reset_n, manual_mem);
    end
    for (int i = 0; i < 5; i++) begin
      din_valid = (i % 2 == 0);
      din = pat[i];
      start = (i % 2 == 1);
      base_addr = 16'h1234;
      len = 16'd9;
      #1;
      if (i % 2 == 1) begin
        total++;
        if (mem_we !== 1'b0) begin
          bad++;
          $display("FAIL gaps_idle_we_%0d: mem_we=%b required 0", i, mem_we);
        end
      end
      step();
    end
    din_valid = 1'b0;
    start = 1'b0;
    wait_done(n);
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL gaps_done_timeout: waited %0d required <40", n);
    end
    step();
    total++;
    if (log_addr.size() !== 3) begin
      bad++;
      $display("FAIL gaps_write_count: got %0d required 3", log_addr.size());
    end else begin
      total++;
      if ({log_addr[0], log_addr[1], log_addr[2], log_data[0], log_data[1], log_data[2]}
          !== {16'h0700, 16'h0701, 16'h0702, 8'h11, 8'h22, 8'h33}) begin
        bad++;
        $display("FAIL gaps_writes: %h %h %h / %h %h %h required 0700 0701 0702 / 11 22 33",
                 log_addr[0], log_addr[1], log_addr[2], log_data[0], log_data[1], log_data[2]);
      end
      total++;
      if (log_cyc[1] - log_cyc[0] !== 2) begin
        bad++;
        $display("FAIL gaps_spacing: got %0d required 2", log_cyc[1] - log_cyc[0]);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    clear_log();
    do_start(16'hFFFE, 16'd4);
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'(i + 1);
      step();
    end
    din_valid = 1'b0;
    wait_done(n);
    total++;
    if (n >= 40 || error !== 1'b0) begin
      bad++;
      $display("FAIL wrap_done: waited %0d error=%b required <40 and 0", n, error);
    end
    step();
    total++;
    if (log_addr.size() !== 4) begin
      bad++;
      $display("FAIL wrap_write_count: got %0d required 4", log_addr.size());
    end else begin
      total++;
      if ({log_addr[0], log_addr[1], log_addr[2], log_addr[3]} !== {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001}) begin
        bad++;
        $display("FAIL wrap_addrs: %h %h %h %h required fffe ffff 0000 0001", log_addr[0], log_addr[1], log_addr[2], log_addr[3]);
      end
    end
  endtask

  task automatic test_len_zero();
    int n;
    do_reset();
    clear_log();
    din_valid = 1'b1;
    din = 8'h5A;
    do_start(16'h0400, 16'd0);
    #1;
    total++;
    if ({busy, cpu_reset_n, manual_mem, din_ready, mem_we} !== 5'b11000) begin
      bad++;
      $display("FAIL len0_release: got %b required 11000", {busy, cpu_reset_n, manual_mem, din_ready, mem_we});
    end
    wait_done(n);
    total++;
    if (n !== GAP) begin
      bad++;
      $display("FAIL len0_trigger_gap: got %0d required %0d", n, GAP);
    end
    din_valid = 1'b0;
    step();
    total++;
    if (log_addr.size() !== 0) begin
      bad++;
      $display("FAIL len0_no_write: got %0d writes required 0", log_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    clear_log();
    do_start(16'h0800, 16'd5);
    din_valid = 1'b1;
    din = 8'hC1;
    step();
    din = 8'hC2;
    step();
    reset_n = 1'b0;
    din = 8'hEE;
    #1;
    total++;
    if (mem_we !== 1'b0) begin
      bad++;
      $display("FAIL midreset_we: mem_we=%b required 0", mem_we);
    end
    step();
    reset_n = 1'b1;
    total++;
    if ({din_ready, cpu_reset_n, manual_mem, busy, mem_addr} !== {4'b0010, 16'h0000}) begin
      bad++;
      $display("FAIL midreset_idle: rdy=%b cpu=%b man=%b busy=%b addr=%h required 0 0 1 0 0000",
               din_ready, cpu_reset_n, manual_mem, busy, mem_addr);
    end
    step(); step(); step();
    din_valid = 1'b0;
    total++;
    if (log_addr.size() !== 2) begin
      bad++;
      $display("FAIL midreset_writes: got %0d required 2", log_addr.size());
    end
    do_start(16'h0900, 16'd2);
    din_valid = 1'b1;
    din = 8'h5A;
    step();
    din = 8'hA5;
    step();
    din_valid = 1'b0;
    wait_done(n);
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL midreset_restart_timeout: waited %0d required <40", n);
    end
    step();
    total++;
    if (log_addr.size() !== 4 || mem_model[16'h0800] !== 8'hC1 || mem_model[16'h0801] !== 8'hC2 ||
        mem_model[16'h0900] !== 8'h5A || mem_model[16'h0901] !== 8'hA5) begin
      bad++;
      $display("FAIL midreset_memory: writes=%0d m800=%h m801=%h m900=%h m901=%h required 4 c1 c2 5a a5",
               log_addr.size(), mem_model[16'h0800], mem_model[16'h0801], mem_model[16'h0900], mem_model[16'h0901]);
    end
  endtask

`ifdef MEM_LOADER_VERIFY_EN
  task automatic test_verify_error();
    int n;
    int trig0;
    do_reset();
    corrupt_addr = 16'h0A01;
    corrupt_en = 1'b1;
    trig0 = trig_cnt;
    do_start(16'h0A00, 16'd3);
    din_valid = 1'b1;
    din = 8'h10; step();
    din = 8'h20; step();
    din = 8'h30; step();
    din_valid = 1'b0;
    n = 0;
    while (error !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step(); step(); step();
    total++;
    if ({error, busy, cpu_reset_n, manual_mem} !== 4'b1001) begin
      bad++;
      $display("FAIL verify_error: err=%b busy=%b cpu=%b man=%b required 1 0 0 1", error, busy, cpu_reset_n, manual_mem);
    end
    total++;
    if (trig_cnt !== trig0) begin
      bad++;
      $display("FAIL verify_no_trigger: pulses=%0d required 0", trig_cnt - trig0);
    end
    corrupt_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_len_zero();
    test_reset_mid();
`ifdef MEM_LOADER_VERIFY_EN
    test_verify_error();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 Parameter REG_WIDTH, default 8, data byte width.
REQ-003 Parameter RELEASE_GAP, default 1, number of cycles between cpu_reset_n rising and the trigger_program pulse; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 start  in  1  one-cycle request to begin a load session.
REQ-007 base_addr  in  ADDR_WIDTH  first memory address of the session, sampled with start.
REQ-008 len  in  ADDR_WIDTH  byte count of the session, sampled with start.
REQ-009 din  in  REG_WIDTH  stream byte to be written.
REQ-010 din_valid  in  1  din carries a byte.
REQ-011 din_ready  out  1  loader accepts din this cycle.
REQ-012 mem_addr  out  ADDR_WIDTH  memory address.
REQ-013 mem_din  out  REG_WIDTH  memory write data.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_dout  in  REG_WIDTH  memory read data, valid one cycle after mem_addr is presented.
REQ-016 manual_mem  out  1  high while the loader owns the memory port (address/data/we mux select).
REQ-017 cpu_reset_n  out  1  active-low reset driven to the CPU.
REQ-018 trigger_program  out  1  one-cycle pulse that starts instruction fetch.
REQ-019 busy  out  1  session in progress; done  out  1  one-cycle pulse at session success; error  out  1  sticky failure flag.

Function
REQ-020 States SHALL be IDLE, LOAD, VERIFY, RELEASE, RUN.
REQ-021 IDLE: manual_mem=1, cpu_reset_n=0, din_ready=0; start=1 latches base_addr/len, clears error and the checksum, and moves to LOAD.
REQ-022 LOAD: din_ready=1; each cycle with din_valid=1 SHALL drive mem_we=1, mem_addr=current address, mem_din=din in that same cycle (zero latency), then increment the address and decrement the remaining count.
REQ-023 A cycle with din_valid=0 in LOAD SHALL drive mem_we=0 and hold the address and count.
REQ-024 The address SHALL wrap modulo 2^ADDR_WIDTH (0xFFFF+1 -> 0x0000) with no error.
REQ-025 After the final byte is accepted, din_ready SHALL be 0 in the next cycle, and the FSM SHALL move to VERIFY (REQ-036) or RELEASE.
REQ-026 len=0 SHALL skip LOAD and VERIFY and go directly to RELEASE with no memory write.
REQ-027 RELEASE: manual_mem=0, and cpu_reset_n=1 from the first RELEASE cycle. trigger_program SHALL pulse high for exactly one cycle RELEASE_GAP cycles later, together with done, and the FSM then moves to RUN.
REQ-028 RUN: manual_mem=0, cpu_reset_n=1, busy=0. A start in RUN SHALL set cpu_reset_n=0 and manual_mem=1 in the next cycle and begin a new session.
REQ-029 A start received in LOAD, VERIFY or RELEASE SHALL be ignored.
REQ-030 din_valid outside LOAD SHALL be ignored, with no write.
REQ-031 busy SHALL be 1 in LOAD, VERIFY and RELEASE, and 0 otherwise.
REQ-032 On error the FSM SHALL return to IDLE with cpu_reset_n=0 and trigger_program never pulsed.

Reset
REQ-033 When reset_n=0 at a clock edge: state=IDLE, manual_mem=1, cpu_reset_n=0, mem_we=0, din_ready=0, trigger_program=0, done=0, busy=0, error=0, and mem_addr, mem_din and the internal counters SHALL be 0.
REQ-034 Reset in any state, including mid-LOAD, SHALL abandon the session. Bytes already written SHALL remain in memory and no further write SHALL occur.
REQ-035 cpu_reset_n SHALL never be 1 while manual_mem=1.

Configuration
REQ-036 Macro MEM_LOADER_VERIFY_EN, when defined, SHALL compile in the following: an 8-bit XOR checksum of all accepted bytes, and a VERIFY state. VERIFY re-reads base_addr..base_addr+len-1, one address per cycle, pipelined against the 1-cycle read latency, and XORs mem_dout. A mismatch SHALL set error and go to IDLE; a match SHALL go to RELEASE. When the macro is undefined, LOAD SHALL go directly to RELEASE and error SHALL be tied to 0.

Verification
REQ-037 Reset, then start with base=0x0600, len=3, bytes A9,05,00 sent back-to-back -> three writes at 0600/0601/0602 in consecutive cycles; cpu_reset_n rises; trigger_program pulses RELEASE_GAP cycles later.
REQ-038 din_valid toggling 1,0,1,0,1 with len=3 -> exactly 3 writes at consecutive addresses; mem_we=0 in the gap cycles.
REQ-039 base=0xFFFE, len=4 -> writes at FFFE, FFFF, 0000, 0001.
REQ-040 len=0 -> no mem_we; RELEASE is entered the cycle after start.
REQ-041 reset_n=0 after 2 of 5 bytes -> IDLE and cpu_reset_n=0, with no further writes; a restart then completes normally.
REQ-042 With MEM_LOADER_VERIFY_EN defined, force mem_dout of the second readback to 0xFF -> error=1, trigger_program never pulses, cpu_reset_n stays 0.
